// File: rtl/mini_alu_pkg.sv
// Shared Mini-ALU definitions: comparator FSM state encodings and digit helpers.
// One digit is two operand bits; the serial comparator walks W/2 digits.
package mini_alu_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } cmp_state_t;

    function automatic int digit_count(input int width);
        return width / 2;
    endfunction

endpackage

// File: rtl/two_bit_greater.sv
// Team 2-bit comparator slice: gt_o is high when a_i > b_i (unsigned).
module two_bit_greater (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic       gt_o
);

    assign gt_o = (a_i[1] & ~b_i[1])
                | (~(a_i[1] ^ b_i[1]) & a_i[0] & ~b_i[0]);

endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// Serial unsigned magnitude comparator: two bits per cycle, MSB digit first,
// stops at the first differing digit and reports how many digits it examined.
//
// state   | meaning
// ST_IDLE | waiting for start; results hold
// ST_SCAN | comparing digit idx, one digit per cycle
module serial_mag_compare_ctrl
    import mini_alu_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = $clog2(W / 2) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          busy,
    output logic          done,
    output logic          a_gt_b,
    output logic          a_eq_b,
    output logic          a_lt_b,
    output logic [CW-1:0] steps
);

    localparam int DIGITS = digit_count(W);
    localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if ((W < 2) || ((W % 2) != 0)) begin : g_bad_width
        $error("serial_mag_compare_ctrl: W must be even and >= 2");
    end

    cmp_state_t    state_q, state_d;
    logic [W-1:0]  op_a_q, op_a_d;
    logic [W-1:0]  op_b_q, op_b_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          done_q, done_d;
    logic          gt_q, gt_d;
    logic          eq_q, eq_d;
    logic          lt_q, lt_d;
    logic [CW-1:0] steps_q, steps_d;

    logic [1:0]    dig_a, dig_b;
    logic          dig_gt, dig_lt;

    assign dig_a = op_a_q[{idx_q, 1'b0} +: 2];
    assign dig_b = op_b_q[{idx_q, 1'b0} +: 2];

    // Same slice used in both directions gives gt and lt without a 3-way cell.
    two_bit_greater u_gt_ab (
        .a_i  (dig_a),
        .b_i  (dig_b),
        .gt_o (dig_gt)
    );

    two_bit_greater u_gt_ba (
        .a_i  (dig_b),
        .b_i  (dig_a),
        .gt_o (dig_lt)
    );

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        steps_d = steps_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_a_d  = a;
                    op_b_d  = b;
                    idx_d   = IW'(DIGITS - 1);
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (dig_gt || dig_lt || (idx_q == '0)) begin
                    gt_d    = dig_gt;
                    lt_d    = dig_lt;
                    eq_d    = ~dig_gt & ~dig_lt;
                    steps_d = CW'(DIGITS) - CW'(idx_q);
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b1;
            lt_q    <= 1'b0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            steps_q <= steps_d;
        end
    end

    assign busy   = (state_q == ST_SCAN);
    assign done   = done_q;
    assign a_gt_b = gt_q;
    assign a_eq_b = eq_q;
    assign a_lt_b = lt_q;
    assign steps  = steps_q;

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Directed bench for serial_mag_compare_ctrl (W=8) with hand-computed results.
module tb_serial_mag_compare_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W / 2) + 1;

    logic          clk;
    logic          reset;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic          a_gt_b;
    logic          a_eq_b;
    logic          a_lt_b;
    logic [CW-1:0] steps;

    int n_checks;
    int n_errors;

    serial_mag_compare_ctrl #(.W(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .a_gt_b (a_gt_b),
        .a_eq_b (a_eq_b),
        .a_lt_b (a_lt_b),
        .steps  (steps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input int gt, input int eq,
                                input int lt, input int st);
        check_val({tag, " gt"}, int'(a_gt_b), gt);
        check_val({tag, " eq"}, int'(a_eq_b), eq);
        check_val({tag, " lt"}, int'(a_lt_b), lt);
        check_val({tag, " steps"}, int'(steps), st);
    endtask

    // Launch one comparison and follow it to done; optionally scramble inputs mid-scan.
    task automatic do_cmp(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input int gt, input int eq, input int lt, input int st,
                          input bit scramble);
        int cyc;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val({tag, " busy after start"}, int'(busy), 1);
        cyc = 0;
        while (!done && cyc < 20) begin
            if (scramble) begin
                a = ~av; b = ~bv;
            end
            @(negedge clk);
            cyc++;
        end
        check_val({tag, " latency"}, cyc, st);
        check_val({tag, " done"}, int'(done), 1);
        check_val({tag, " busy at done"}, int'(busy), 0);
        check_result(tag, gt, eq, lt, st);
        @(negedge clk);
        check_val({tag, " done one pulse"}, int'(done), 0);
        check_val({tag, " idle after"}, int'(busy), 0);
        check_result({tag, " hold"}, gt, eq, lt, st);
    endtask

    initial begin
        int n_done;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_val("rst busy", int'(busy), 0);
        check_val("rst done", int'(done), 0);
        check_result("rst", 0, 1, 0, 0);

        do_cmp("gt_msb", 8'hB4, 8'h74, 1, 0, 0, 1, 1'b0);
        do_cmp("eq_all", 8'h5A, 8'h5A, 0, 1, 0, 4, 1'b0);
        do_cmp("lt_lsb", 8'h12, 8'h13, 0, 0, 1, 4, 1'b1);
        do_cmp("gt_d3",  8'h3C, 8'h38, 1, 0, 0, 3, 1'b0);
        do_cmp("lt_msb", 8'h80, 8'hC0, 0, 0, 1, 1, 1'b0);

        // Second start during scan must be ignored, not queued.
        @(negedge clk);
        a = 8'h00; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        check_val("ign busy", int'(busy), 1);
        a = 8'hFF; b = 8'h00;
        @(negedge clk);
        start = 1'b0;
        check_val("ign done", int'(done), 1);
        check_result("ign", 0, 0, 1, 1);
        @(negedge clk);
        check_val("ign no requeue busy", int'(busy), 0);
        check_val("ign no requeue done", int'(done), 0);

        // Reset in the middle of a scan discards it without a done pulse.
        do_cmp("pre_rst", 8'h40, 8'h80, 0, 0, 1, 1, 1'b0);
        @(negedge clk);
        a = 8'h55; b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("mid busy1", int'(busy), 1);
        @(negedge clk);
        check_val("mid busy2", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("mid rst busy", int'(busy), 0);
        check_val("mid rst done", int'(done), 0);
        check_result("mid rst", 0, 1, 0, 0);
        n_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check_val("mid rst no done", n_done, 0);
        do_cmp("post_rst", 8'h12, 8'h13, 0, 0, 1, 4, 1'b0);

        // Start held high: one comparison every two cycles.
        @(negedge clk);
        a = 8'hC0; b = 8'h40; start = 1'b1;
        n_done = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check_val("hold busy&done", int'(busy && done), 0);
            check_val("hold busy alt", int'(busy), i % 2);
            if (done) begin
                n_done++;
                check_result("hold", 1, 0, 0, 1);
            end
        end
        start = 1'b0;
        check_val("hold done count", n_done, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
